// File: rtl/tone_sequencer.sv
// Purpose : plays {note, duration} entries from a synchronous score ROM as a square wave.
// Latency : score_data sampled 2 cycles after score_addr changes; 2-cycle gap between notes.
// Backpressure: none; start is ignored while busy, stop aborts from any state on the next cycle.
//
// Optional feature macro: TONE_SEQ_LOOP_EN
//   defined   -> the terminator entry (dur == 0) restarts the score at address 0
//                and busy stays high until stop or rst; done still pulses per pass.
//   undefined -> the terminator returns the sequencer to IDLE.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        1-cycle pulse, begins playback at address 0 (IDLE only)
//   stop         1-cycle pulse, aborts playback (wins over start)
//   score_addr   ROM address; score_data = {note[23:16], dur[15:0]} one cycle later
//   note_num     registered note number to the external note-to-frequency scaler
//   freq_x100    scaler result (Hz x100), combinational from note_num
//   tone_out     square wave for the audio PWM pin
//   busy         high whenever the sequencer is not idle
//   done         1-cycle pulse when the terminator entry is reached
module tone_sequencer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [23:0]       score_data,
  output logic [7:0]        note_num,
  input  logic [31:0]       freq_x100,
  output logic              tone_out,
  output logic              busy,
  output logic              done
);

  // Cycles per duration tick.
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Phase wrap threshold: freq_x100 accumulates once per cycle, so crossing
  // CLK_HZ*50 corresponds to half a period of the requested frequency.
  localparam logic [40:0] ACC_LIM = 41'(64'(CLK_HZ) * 64'd50);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t            state;
  logic [15:0]       dur_cnt;
  logic [PRE_W-1:0]  presc;
  logic [39:0]       acc;
  logic              play_rest;

  logic [7:0]        score_note;
  logic [15:0]       score_dur;
  logic              note_is_rest;
  logic [40:0]       acc_sum;
  logic              tick_last;

  assign score_note = score_data[23:16];
  assign score_dur  = score_data[15:0];

  // Notes outside the scaler's 1..88 range play as silence; the scaler's
  // fallback output for such notes must never reach the accumulator.
  assign note_is_rest = (score_note == 8'd0) || (score_note > 8'd88);

  // One extra bit so the sum can never wrap before it is compared.
  assign acc_sum   = {1'b0, acc} + {9'd0, freq_x100};
  assign tick_last = (presc == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      score_addr <= '0;
      note_num   <= '0;
      tone_out   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dur_cnt    <= '0;
      presc      <= '0;
      acc        <= '0;
      play_rest  <= 1'b0;
    end else if (stop) begin
      // Abort from any state; the address is deliberately left where it was.
      state     <= S_IDLE;
      note_num  <= '0;
      tone_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dur_cnt   <= '0;
      presc     <= '0;
      acc       <= '0;
      play_rest <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_FETCH;
            score_addr <= '0;
            busy       <= 1'b1;
          end
        end

        // score_addr is stable this cycle; the ROM registers it at this edge,
        // so the word is on score_data during LOAD.
        S_FETCH: begin
          state <= S_LOAD;
        end

        S_LOAD: begin
          if (score_dur == 16'd0) begin
            done     <= 1'b1;
            tone_out <= 1'b0;
`ifdef TONE_SEQ_LOOP_EN
            score_addr <= '0;
            state      <= S_FETCH;
`else
            state      <= S_IDLE;
            busy       <= 1'b0;
`endif
          end else begin
            note_num  <= score_note;
            dur_cnt   <= score_dur;
            presc     <= '0;
            acc       <= '0;
            play_rest <= note_is_rest;
            // A tone keeps its level across the gap; a rest silences at once.
            if (note_is_rest) begin
              tone_out <= 1'b0;
            end
            state <= S_PLAY;
          end
        end

        S_PLAY: begin
          // Tone generation.
          if (play_rest) begin
            acc <= '0;
          end else if (acc_sum >= ACC_LIM) begin
            acc      <= 40'(acc_sum - ACC_LIM);
            tone_out <= ~tone_out;
          end else begin
            acc <= acc_sum[39:0];
          end

          // Duration timing: the note ends on the last cycle of its last tick,
          // giving exactly dur*TICK_DIV cycles in PLAY.
          if (tick_last) begin
            presc   <= '0;
            dur_cnt <= dur_cnt - 16'd1;
            if (dur_cnt == 16'd1) begin
              score_addr <= score_addr + ADDR_W'(1);
              state      <= S_FETCH;
            end
          end else begin
            presc <= presc + PRE_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Purpose : directed bench for tone_sequencer with a per-cycle expectation queue.
// Latency : model queue entries are built when start is driven, one per visible cycle.
// Backpressure: n/a; ROM and scaler are modelled inside the bench.
module tb_tone_sequencer;

  localparam int     CLK_HZ  = 1_000_000;
  localparam int     TICK_HZ = 1000;
  localparam int     ADDR_W  = 8;
  localparam longint TPT     = 1000;          // cycles per tick
  localparam longint LIM     = 50_000_000;    // CLK_HZ*50

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] score_addr;
  logic [23:0]       score_data;
  logic [7:0]        note_num;
  logic [31:0]       freq_x100;
  logic              tone_out;
  logic              busy;
  logic              done;

  tone_sequencer #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .score_addr(score_addr),
    .score_data(score_data),
    .note_num  (note_num),
    .freq_x100 (freq_x100),
    .tone_out  (tone_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Score ROM: synchronous, one cycle of latency.
  logic [23:0] rom [256];
  always @(posedge clk) score_data <= rom[score_addr];

  // Scaler stand-in: table covers the notes used by these scores.
  function automatic longint note_freq(input logic [7:0] n);
    case (n)
      8'd37:   return 22000;
      8'd49:   return 44000;
      8'd61:   return 88000;
      default: return 1;
    endcase
  endfunction
  assign freq_x100 = 32'(note_freq(note_num));

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       tone;
    logic [7:0] addr;
    logic [7:0] note;
  } exp_t;

  exp_t q[$];
  exp_t idle;
  logic cmp_en;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic t,
                              input int a, input logic [7:0] n);
    exp_t e;
    e.busy = b;
    e.done = d;
    e.tone = t;
    e.addr = a[7:0];
    e.note = n;
    return e;
  endfunction

  // Expected output sequence for a whole play, derived from the score:
  // 2 gap cycles per entry, dur*TPT note cycles, tone level from the closed
  // form parity(floor(j*f/LIM)) counted from the start of the note.
  task automatic build_play();
    int         a;
    int         pass;
    logic       t;
    logic       pend_done;
    logic [7:0] nt;
    logic [23:0] w;
    logic       is_rest;
    longint     f;
    longint     np;
    a = 0; pass = 0; t = 1'b0; pend_done = 1'b0; nt = idle.note;
    q.push_back(idle);   // the cycle in which start is being sampled
    while (1) begin
      q.push_back(mk(1'b1, pend_done, t, a, nt));
      q.push_back(mk(1'b1, 1'b0, t, a, nt));
      pend_done = 1'b0;
      w = rom[a];
      if (w[15:0] == 16'd0) begin
        t = 1'b0;
        pass++;
`ifdef TONE_SEQ_LOOP_EN
        if (pass < 4) begin
          a = 0;
          pend_done = 1'b1;
        end else begin
          break;
        end
`else
        q.push_back(mk(1'b0, 1'b1, 1'b0, a, nt));
        idle = mk(1'b0, 1'b0, 1'b0, a, nt);
        break;
`endif
      end else begin
        nt      = w[23:16];
        is_rest = (nt == 8'd0) || (nt > 8'd88);
        f       = is_rest ? 0 : note_freq(nt);
        if (is_rest) t = 1'b0;
        np = longint'(w[15:0]) * TPT;
        for (longint j = 0; j < np; j++)
          q.push_back(mk(1'b1, 1'b0, t ^ (((j * f) / LIM) % 2 != 0), a, nt));
        t = t ^ (((np * f) / LIM) % 2 != 0);
        a = (a + 1) % 256;
      end
    end
  endtask

  // Stop is sampled at the end of the current cycle; that cycle is unchanged.
  task automatic apply_stop();
    exp_t e;
    e = (q.size() > 0) ? q[0] : idle;
    q.delete();
    q.push_back(e);
    idle = mk(1'b0, 1'b0, 1'b0, int'(e.addr), 8'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    build_play();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 24'd0;
  endtask

  // Single compare process against the model, every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      e = (q.size() > 0) ? q.pop_front() : idle;
      checks++;
      if ({busy, done, tone_out, score_addr, note_num} !== e) begin
        errors++;
        $display("FAIL cycle_outputs @%0t: got busy=%b done=%b tone=%b addr=%0d note=%0d expected busy=%b done=%b tone=%b addr=%0d note=%0d",
                 $time, busy, done, tone_out, score_addr, note_num,
                 e.busy, e.done, e.tone, e.addr, e.note);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt, done_at, tone_hi;
    int edges, first, last, imin, imax;
    logic prev;

    rst = 1'b1; start = 1'b0; stop = 1'b0; cmp_en = 1'b0;
    idle = '0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_tone", tone_out, 0);
    check("reset_addr", score_addr, 0);
    check("reset_note", note_num, 0);
    cmp_en = 1'b1;

`ifndef TONE_SEQ_LOOP_EN
    // {49,2},{0,1},{0,0}
    clear_rom();
    rom[0] = {8'd49, 16'd2}; rom[1] = {8'd0, 16'd1}; rom[2] = 24'd0;
    pulse_start();
    busy_cnt = 0; done_cnt = 0; done_at = 0; tone_hi = 0;
    for (int n = 1; n <= 3015; n++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      tone_hi  += int'(tone_out);
      if (done) begin done_cnt++; done_at = n; end
      if (n == 3) check("t1_note_first_play", note_num, 49);
    end
    check("t1_busy_cycles", busy_cnt, 3006);
    check("t1_done_count", done_cnt, 1);
    check("t1_done_cycle", done_at, 3007);
    check("t1_tone_high_cycles", tone_hi, 865);
    check("t1_model_drained", q.size(), 0);

    // {200,1},{0,0}: out-of-range note is a rest
    clear_rom();
    rom[0] = {8'd200, 16'd1};
    pulse_start();
    done_at = 0; tone_hi = 0;
    for (int n = 1; n <= 1010; n++) begin
      @(negedge clk);
      tone_hi += int'(tone_out);
      if (done) done_at = n;
      if (n == 3) check("t2_note", note_num, 200);
    end
    check("t2_tone_high_cycles", tone_hi, 0);
    check("t2_done_cycle", done_at, 1005);

    // {61,3},{0,0}: 880 Hz half period 568.18 cycles
    clear_rom();
    rom[0] = {8'd61, 16'd3};
    pulse_start();
    prev = 1'b0; edges = 0; first = 0; last = 0; imin = 100000; imax = 0;
    for (int n = 1; n <= 3010; n++) begin
      @(negedge clk);
      if (busy && tone_out !== prev) begin
        edges++;
        if (edges == 1) first = n;
        else begin
          if (n - last < imin) imin = n - last;
          if (n - last > imax) imax = n - last;
        end
        last = n;
      end
      prev = tone_out;
    end
    check("t3_edges", edges, 5);
    check("t3_first_edge", first, 572);
    check("t3_min_interval", imin, 568);
    check("t3_max_interval", imax, 568);

    // Stop 500 cycles into the second note, then restart from address 0
    clear_rom();
    rom[0] = {8'd61, 16'd1}; rom[1] = {8'd49, 16'd5};
    pulse_start();
    repeat (1504) @(negedge clk);
    @(posedge clk); #1;
    stop = 1'b1;
    apply_stop();
    @(negedge clk);
    check("t4_tone_before_stop", tone_out, 1);
    check("t4_addr_before_stop", score_addr, 1);
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("t4_busy_after_stop", busy, 0);
    check("t4_tone_after_stop", tone_out, 0);
    check("t4_note_after_stop", note_num, 0);
    check("t4_addr_kept", score_addr, 1);
    done_cnt = 0;
    repeat (20) begin @(negedge clk); done_cnt += int'(done); end
    check("t4_no_done", done_cnt, 0);
    pulse_start();
    @(negedge clk);
    check("t4_restart_addr", score_addr, 0);
    check("t4_restart_busy", busy, 1);
    repeat (100) @(negedge clk);
    @(posedge clk); #1;
    stop = 1'b1;
    apply_stop();
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (5) @(negedge clk);

    // start and stop together from IDLE
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    apply_stop();
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    busy_cnt = 0;
    repeat (10) begin @(negedge clk); busy_cnt += int'(busy); end
    check("t5_start_stop_idle", busy_cnt, 0);

    // start during PLAY has no effect
    clear_rom();
    rom[0] = {8'd49, 16'd1};
    pulse_start();
    repeat (200) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t6_addr_unchanged", score_addr, 0);
    done_at = 0;
    for (int n = 203; n <= 1010; n++) begin
      @(negedge clk);
      if (done) done_at = n;
    end
    check("t6_done_cycle", done_at, 1005);

    // Asynchronous reset mid-play
    clear_rom();
    rom[0] = {8'd49, 16'd1}; rom[1] = {8'd61, 16'd2};
    pulse_start();
    repeat (1705) @(negedge clk);
    check("t7_tone_before_rst", tone_out, 1);
    check("t7_note_before_rst", note_num, 61);
    #2;
    rst = 1'b1;
    q.delete();
    idle = '0;
    #1;
    check("t7_rst_tone", tone_out, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_addr", score_addr, 0);
    check("t7_rst_note", note_num, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
`else
    // Looping score {61,1},{0,0}
    clear_rom();
    rom[0] = {8'd61, 16'd1};
    pulse_start();
    done_cnt = 0; busy_cnt = 0;
    for (int n = 1; n <= 3312; n++) begin
      @(negedge clk);
      done_cnt += int'(done);
      busy_cnt += int'(!busy);
      if (n == 3) check("loop_note", note_num, 61);
    end
    check("loop_done_count", done_cnt, 3);
    check("loop_busy_low_cycles", busy_cnt, 0);
    @(posedge clk); #1;
    stop = 1'b1;
    apply_stop();
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("loop_busy_after_stop", busy, 0);
    repeat (5) @(negedge clk);
`endif

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
